// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier controller.
// Holds the controller state encoding, the digit-count function and the pp correction helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest partial product the helper can form; bounds N to 30 (2N+3 <= 64).
    localparam int PP_MAXW = 64;

    function automatic int ndig(input int n);
        return (n + 2) / 2;
    endfunction

    // Sign-extend {neg, sel_out[n:0]} to PP_MAXW bits and add the +1 that turns
    // the selector's one's complement into a two's complement value.
    function automatic logic [PP_MAXW-1:0] pp_correct(
        input logic               neg,
        input logic [PP_MAXW-1:0] sel_out,
        input int                 n
    );
        logic [PP_MAXW-1:0] ext;
        for (int k = 0; k < PP_MAXW; k++) begin
            ext[k] = (k > n) ? neg : sel_out[k];
        end
        return ext + PP_MAXW'(neg);
    endfunction

endpackage

// File: rtl/booth_sel.sv
// Radix-4 Booth partial-product selector: maps a 3-bit digit code and A to
// {0, A, 2A} or its one's complement for negative codes.
module booth_sel #(
    parameter int N = 10
) (
    input  logic [2:0]   sel,
    input  logic [N-1:0] a_in,
    output logic [N:0]   out
);

    logic       one;
    logic       two;
    logic       neg;
    logic [N:0] a1;
    logic [N:0] a2;

    assign one = sel[0] ^ sel[1];
    assign two = (sel == 3'b011) | (sel == 3'b100);
    assign neg = sel[2];
    assign a1  = {1'b0, a_in};
    assign a2  = {a_in, 1'b0};

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_bit
            assign out[gi] = ((one & a1[gi]) | (two & a2[gi])) ^ neg;
        end
    endgenerate

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one Booth digit per cycle, 2N-bit product.
// Optional BOOTH_CTRL_EARLY_TERM_EN stops once the remaining multiplier bits are all zero.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int NDIG = ndig(N);
    localparam int AW   = 2 * N + 3;
    localparam int PW   = 2 * N;
    localparam int CW   = $clog2(NDIG);
    localparam int BEW  = 2 * NDIG + 1;

`ifdef BOOTH_CTRL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    state_t          state_reg;
    state_t          state_next;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [AW-1:0]   acc_reg;
    logic [AW-1:0]   acc_next;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   product_reg;
    logic            load;
    logic            step;
    logic            last_digit;

    logic [BEW-1:0]  b_ext;
    logic [2:0]      digits [NDIG];
    logic [NDIG-1:0] rest_zero;
    logic [2:0]      sel;
    logic [N:0]      sel_out;

    // b[-1] = 0 below, zero padding above so the top digit sees a positive code.
    assign b_ext = {{(BEW-N-1){1'b0}}, b_reg, 1'b0};

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign digits[gi]    = b_ext[2*gi+2 -: 3];
            assign rest_zero[gi] = ~|(b_ext >> (2*gi + 2));
        end
    endgenerate

    assign sel = digits[cnt_reg];

    booth_sel #(.N(N)) u_sel (
        .sel  (sel),
        .a_in (a_reg),
        .out  (sel_out)
    );

    always_comb begin
        acc_next = acc_reg
                 + (AW'(pp_correct(sel[2], PP_MAXW'(sel_out), N)) << {cnt_reg, 1'b0});
    end

    assign last_digit = (cnt_reg == CW'(NDIG - 1)) || (EARLY_TERM && rest_zero[cnt_reg]);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else if (load) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (step) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            // Product only changes on the transition into DONE.
            if (last_digit) begin
                product_reg <= acc_next[PW-1:0];
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == DONE);
    assign product   = product_reg;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and randomised self-checking bench for booth_seq_ctrl (N=10 and N=9 instances).
// Expected latency follows BOOTH_CTRL_EARLY_TERM_EN when it is defined.
module tb_booth_seq_ctrl;

    localparam int N     = 10;
    localparam int NDIG  = (N + 2) / 2;
    localparam int N9    = 9;
    localparam int NDIG9 = (N9 + 2) / 2;

`ifdef BOOTH_CTRL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, out_valid, out_ready, busy;
    logic [N-1:0]    a_in, b_in;
    logic [2*N-1:0]  product;
    logic            in_valid9, in_ready9, out_valid9, out_ready9, busy9;
    logic [N9-1:0]   a_in9, b_in9;
    logic [2*N9-1:0] product9;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    booth_seq_ctrl #(.N(N9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid9), .in_ready(in_ready9), .a_in(a_in9), .b_in(b_in9),
        .out_valid(out_valid9), .out_ready(out_ready9), .product(product9), .busy(busy9)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
            $error("%s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int b, input int nd);
        int l;
        l = nd;
        if (EARLY) begin
            for (int i = nd - 1; i >= 0; i--) begin
                if ((b >> (2*i + 1)) == 0) l = i + 1;
            end
        end
        return l;
    endfunction

    // Caller is 1 time unit after a rising edge with the DUT idle.
    task automatic do_op(input int a, input int b, input string tag);
        int lat;
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; a_in = N'(a); b_in = N'(b);
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = N'($urandom); b_in = N'($urandom);
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat(b, NDIG));
        chk({tag, "_product"}, product, a * b);
        chk({tag, "_acc_top"}, dut.acc_reg[2*N+2:2*N], 0);
        $display("op %s a=%0d b=%0d product=%0d latency=%0d", tag, a, b, product, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_product_hold"}, product, a * b);
    endtask

    initial begin
        int guard, n_acc, n_out, ra, rb;
        bit done;
        rst_n = 1'b1; in_valid = 0; out_ready = 0; a_in = '0; b_in = '0;
        in_valid9 = 0; out_ready9 = 0; a_in9 = '0; b_in9 = '0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);

        do_op(5, 3, "a5_b3");
        do_op(1023, 1023, "amax_bmax");
        do_op(0, 682, "a0_b682");
        do_op(1023, 0, "amax_b0");
        do_op(1023, 1, "amax_b1");
        do_op(682, 512, "a682_b512");

        // Consumer stall: DONE holds, in_valid ignored.
        in_valid = 1'b1; a_in = 10'd37; b_in = 10'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("stall_reach_done", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; a_in = N'($urandom); b_in = N'($urandom);
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_product", product, 3700);
            chk("stall_in_ready", in_ready, 0);
            $display("stall cycle=%0d out_valid=%0d product=%0d", c, out_valid, product);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release_ready", in_ready, 1);
        chk("stall_release_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("stall_no_ghost_busy", busy, 0);
        chk("stall_idle_product", product, 3700);

        // Reset during RUN.
        in_valid = 1'b1; a_in = 10'd500; b_in = 10'd600;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_product", product, 0);
        chk("midrst_acc", dut.acc_reg, 0);
        chk("midrst_cnt", dut.cnt_reg, 0);
        $display("reset mid-run in_ready=%0d busy=%0d product=%0d", in_ready, busy, product);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(7, 9, "after_rst");

        // Random back-to-back traffic with random consumer backpressure, N=10.
        n_acc = 0; n_out = 0;
        for (int t = 0; t < 300; t++) begin
            ra = $urandom_range(0, 1023); rb = $urandom_range(0, 1023);
            in_valid = 1'b1; a_in = N'(ra); b_in = N'(rb);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_acc++;
            done = 0; guard = 0;
            while (!done && guard < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("rand10_product", product, ra * rb);
                    $display("rand10 t=%0d a=%0d b=%0d product=%0d", t, ra, rb, product);
                    done = 1; n_out++;
                end
                @(posedge clk); #1;
                guard++;
            end
            out_ready = 1'b0;
            chk("rand10_complete", done, 1);
            chk("rand10_no_dup", out_valid, 0);
            chk("rand10_ready", in_ready, 1);
        end
        chk("rand10_count", n_out, n_acc);

        // Random traffic on the N=9 instance.
        n_acc = 0; n_out = 0;
        for (int t = 0; t < 100; t++) begin
            ra = $urandom_range(0, 511); rb = $urandom_range(0, 511);
            in_valid9 = 1'b1; a_in9 = N9'(ra); b_in9 = N9'(rb);
            @(posedge clk); #1;
            in_valid9 = 1'b0;
            n_acc++;
            done = 0; guard = 0;
            while (!done && guard < 200) begin
                out_ready9 = 1'($urandom_range(0, 1));
                if (out_valid9 && out_ready9) begin
                    chk("rand9_product", product9, ra * rb);
                    chk("rand9_acc_top", dut9.acc_reg[2*N9+2:2*N9], 0);
                    $display("rand9 t=%0d a=%0d b=%0d product=%0d", t, ra, rb, product9);
                    done = 1; n_out++;
                end
                @(posedge clk); #1;
                guard++;
            end
            out_ready9 = 1'b0;
            chk("rand9_complete", done, 1);
            chk("rand9_no_dup", out_valid9, 0);
        end
        chk("rand9_count", n_out, n_acc);
        chk("rand9_ndig", exp_lat(0, NDIG9) >= 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
